// File: rtl/cacheport_pkg.sv
// Shared definitions for the SDRAM cache-port responder: burst geometry,
// FSM state encoding and the critical-word-first ordering helper.
package cacheport_pkg;

  localparam int BURST_HALFWORDS = 8;
  localparam int LINE_WORDS      = 4;
  localparam int IDX_BITS        = $clog2(BURST_HALFWORDS);
  localparam int WORD_BITS       = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Word within the line for fill index idx; two halfwords per word, wraps in-line.
  function automatic logic [WORD_BITS-1:0] fill_word(input logic [WORD_BITS-1:0] start,
                                                     input logic [IDX_BITS-1:0]  idx);
    return start + idx[IDX_BITS-1:1];
  endfunction

endpackage

// File: rtl/cacheport_linebuf.sv
// 8x16 line buffer: one write port and one registered read port.
// Indices are owned by the responder FSM.
module cacheport_linebuf
  import cacheport_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [15:0]         wr_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [15:0]         rd_data
);

  logic [15:0] entry_reg [BURST_HALFWORDS];
  logic [15:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_reg[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= 16'h0000;
    end else begin
      rd_data_reg <= entry_reg[rd_idx];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sdram_cacheport_responder.sv
// Cache line-fill responder: fetches a 16-byte line as 8 halfwords over a
// req/ack backend, then returns it as one gap-free strobed 8-cycle burst.
module sdram_cacheport_responder
  import cacheport_pkg::*;
#(
  parameter int ADDRBITS       = 25,
  parameter bit CRITICAL_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         sdram_addr,
  input  logic                sdram_req,
  input  logic                sdram_rw,
  output logic                sdram_fill,
  output logic [15:0]         data_from_sdram,
  output logic [ADDRBITS-2:0] mem_addr,
  output logic                mem_req,
  input  logic                mem_ack,
  input  logic [15:0]         mem_rdata,
  output logic                busy,
  output logic                protocol_error
);

  localparam int LINEBITS = ADDRBITS - 4;

  state_t                state_reg, state_next;
  logic [IDX_BITS-1:0]   idx_reg, idx_next;
  logic [LINEBITS-1:0]   line_reg, line_next;
  logic [WORD_BITS-1:0]  start_reg, start_next;
  logic                  mem_req_reg, mem_req_next;
  logic [ADDRBITS-2:0]   mem_addr_reg, mem_addr_next;
  logic                  perr_reg, perr_next;

  logic [IDX_BITS-1:0]   idx_inc;
  logic [IDX_BITS-1:0]   rd_idx;
  logic [15:0]           rd_data;
  logic                  buf_we;
  logic                  last_idx;
  logic [WORD_BITS-1:0]  req_start;
  logic                  unused_addr_bits;

  assign idx_inc   = idx_reg + IDX_BITS'(1);
  assign last_idx  = (idx_reg == IDX_BITS'(BURST_HALFWORDS - 1));
  assign req_start = CRITICAL_FIRST ? sdram_addr[3:2] : '0;
  assign unused_addr_bits = ^{sdram_addr[31:ADDRBITS], sdram_addr[1:0]};

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    line_next     = line_reg;
    start_next    = start_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    perr_next     = perr_reg;
    case (state_reg)
      IDLE: begin
        if (sdram_req) begin
          if (sdram_rw) begin
            line_next     = sdram_addr[ADDRBITS-1:4];
            start_next    = req_start;
            idx_next      = '0;
            mem_req_next  = 1'b1;
            mem_addr_next = {sdram_addr[ADDRBITS-1:4], req_start, 1'b0};
            state_next    = FETCH;
          end else begin
            perr_next = 1'b1;
          end
        end
      end
      FETCH: begin
        // A dropped sdram_req is deliberately ignored: the line is always completed.
        if (mem_ack) begin
          if (last_idx) begin
            mem_req_next = 1'b0;
            idx_next     = '0;
            state_next   = STREAM;
          end else begin
            idx_next      = idx_inc;
            mem_addr_next = {line_reg, fill_word(start_reg, idx_inc), idx_inc[0]};
          end
        end
      end
      STREAM: begin
        if (last_idx) begin
          idx_next   = '0;
          state_next = IDLE;
        end else begin
          idx_next = idx_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      line_reg     <= '0;
      start_reg    <= '0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      perr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      line_reg     <= line_next;
      start_reg    <= start_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      perr_reg     <= perr_next;
    end
  end

  // Read one entry ahead so buffer[j] is on rd_data during stream beat j.
  assign buf_we = (state_reg == FETCH) && mem_ack;
  assign rd_idx = (state_reg == STREAM) ? idx_inc : '0;

  cacheport_linebuf u_linebuf (
    .clk     (clk),
    .reset   (reset),
    .wr_idx  (idx_reg),
    .wr_data (mem_rdata),
    .wr_en   (buf_we),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign sdram_fill      = (state_reg == STREAM) && (idx_reg == '0);
  assign data_from_sdram = (state_reg == STREAM) ? rd_data : 16'h0000;
  assign busy            = (state_reg != IDLE);
  assign mem_req         = mem_req_reg;
  assign mem_addr        = mem_addr_reg;
  assign protocol_error  = perr_reg;

endmodule

// File: tb/tb_sdram_cacheport_responder.sv
// Randomized bench for two responders (critical-word-first and line-order) against
// a transaction-level model, plus hand-computed expectations for the fixed cases.
module tb_sdram_cacheport_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sdram_addr [2];
  logic        sdram_req  [2];
  logic        sdram_rw   [2];
  logic        sdram_fill [2];
  logic [15:0] dfs        [2];
  logic [23:0] mem_addr   [2];
  logic        mem_req    [2];
  logic        mem_ack    [2];
  logic [15:0] mem_rdata  [2];
  logic        busy       [2];
  logic        perr       [2];

  always #5 clk = ~clk;

  sdram_cacheport_responder #(.ADDRBITS(25), .CRITICAL_FIRST(1'b1)) dut_cf (
    .clk(clk), .reset(reset), .sdram_addr(sdram_addr[0]), .sdram_req(sdram_req[0]),
    .sdram_rw(sdram_rw[0]), .sdram_fill(sdram_fill[0]), .data_from_sdram(dfs[0]),
    .mem_addr(mem_addr[0]), .mem_req(mem_req[0]), .mem_ack(mem_ack[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .protocol_error(perr[0]));

  sdram_cacheport_responder #(.ADDRBITS(25), .CRITICAL_FIRST(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .sdram_addr(sdram_addr[1]), .sdram_req(sdram_req[1]),
    .sdram_rw(sdram_rw[1]), .sdram_fill(sdram_fill[1]), .data_from_sdram(dfs[1]),
    .mem_addr(mem_addr[1]), .mem_req(mem_req[1]), .mem_ack(mem_ack[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .protocol_error(perr[1]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  bit ident  = 1'b0;
  int maxdly = 0;

  // Transaction model: phase 0 idle, 1 fetching, 2 streaming.
  int          ph      [2];
  int          nack    [2];
  int          pos     [2];
  bit          mperr   [2];
  logic [23:0] eaddr   [2][8];
  logic [15:0] edata   [2][8];
  bit          armed   [2];
  int          dly     [2];
  bit          late_ack[2];
  int          ack_cnt [2];
  logic [23:0] alog    [2][64];
  int          alog_n  [2];
  logic [15:0] dlog    [2][64];
  int          dlog_n  [2];
  int          accept_cyc [2];
  int          last_ack_cyc [2];
  int          fill_cyc [2];

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst %0d cyc %0d: got %0h, expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (chk_en) begin
        chk(k, "busy", 32'(busy[k]), 32'(ph[k] != 0));
        chk(k, "mem_req", 32'(mem_req[k]), 32'(ph[k] == 1));
        if (ph[k] == 1) chk(k, "mem_addr", 32'(mem_addr[k]), 32'(eaddr[k][nack[k]]));
        chk(k, "sdram_fill", 32'(sdram_fill[k]), 32'(ph[k] == 2 && pos[k] == 0));
        chk(k, "data", 32'(dfs[k]), (ph[k] == 2) ? 32'(edata[k][pos[k]]) : 32'h0);
        chk(k, "protocol_error", 32'(perr[k]), 32'(mperr[k]));
      end
      if (sdram_fill[k] === 1'b1) fill_cyc[k] = cyc;
      if (ph[k] == 2 && dlog_n[k] < 64) begin
        dlog[k][dlog_n[k]] = dfs[k];
        dlog_n[k]++;
      end
      // Backend: random ack delay, data valid with the ack.
      mem_ack[k] = 1'b0;
      if (reset) begin
        armed[k] = 1'b0;
      end else if (late_ack[k]) begin
        mem_ack[k]   = 1'b1;
        mem_rdata[k] = 16'($urandom);
      end else if (mem_req[k] === 1'b1) begin
        if (!armed[k]) begin
          armed[k] = 1'b1;
          dly[k]   = $urandom_range(0, maxdly);
        end
        if (dly[k] == 0) begin
          mem_ack[k]   = 1'b1;
          mem_rdata[k] = ident ? mem_addr[k][15:0] : 16'($urandom);
          armed[k]     = 1'b0;
          ack_cnt[k]++;
          last_ack_cyc[k] = cyc;
          if (alog_n[k] < 64) begin
            alog[k][alog_n[k]] = mem_addr[k];
            alog_n[k]++;
          end
        end else begin
          dly[k]--;
        end
      end
      // Advance the model to the state after the coming rising edge.
      if (reset) begin
        ph[k]    = 0;
        mperr[k] = 1'b0;
      end else if (ph[k] == 0) begin
        if (sdram_req[k]) begin
          if (sdram_rw[k]) begin
            int s;
            s = (k == 0) ? int'(sdram_addr[k][3:2]) : 0;
            for (int i = 0; i < 8; i++)
              eaddr[k][i] = 24'((int'(sdram_addr[k][24:4]) << 3) + ((s + i / 2) % 4) * 2 + (i % 2));
            nack[k]       = 0;
            ph[k]         = 1;
            accept_cyc[k] = cyc;
          end else begin
            mperr[k] = 1'b1;
          end
        end
      end else if (ph[k] == 1) begin
        if (mem_ack[k]) begin
          edata[k][nack[k]] = mem_rdata[k];
          nack[k]++;
          if (nack[k] == 8) begin
            ph[k]  = 2;
            pos[k] = 0;
          end
        end
      end else begin
        pos[k]++;
        if (pos[k] == 8) ph[k] = 0;
      end
    end
  end

  task automatic do_read(input int k, input logic [31:0] a, input int gap);
    int t;
    @(posedge clk); #1;
    sdram_req[k] = 1'b1; sdram_rw[k] = 1'b1; sdram_addr[k] = a;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (sdram_fill[k] !== 1'b1 && t < 200);
    if (sdram_fill[k] !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL fill_timeout inst %0d: no strobe in 200 cycles, expected one", k);
    end
    @(posedge clk); #1;
    sdram_req[k] = 1'b0;
    repeat (6 + gap) @(posedge clk);
  endtask

  task automatic do_write(input int k);
    @(posedge clk); #1;
    sdram_req[k] = 1'b1; sdram_rw[k] = 1'b0; sdram_addr[k] = $urandom;
    @(posedge clk); #1;
    sdram_req[k] = 1'b0; sdram_rw[k] = 1'b1;
    chk(k, "perr_set", 32'(perr[k]), 32'h1);
    chk(k, "write_no_req", 32'(mem_req[k]), 32'h0);
  endtask

  logic [23:0] exp_cf [8];
  int t;

  initial begin
    exp_cf = '{24'h91E, 24'h91F, 24'h918, 24'h919, 24'h91A, 24'h91B, 24'h91C, 24'h91D};
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sdram_req[k] = 1'b0; sdram_rw[k] = 1'b1; sdram_addr[k] = 32'h0;
      mem_ack[k] = 1'b0; mem_rdata[k] = 16'h0; ph[k] = 0; nack[k] = 0; pos[k] = 0;
      mperr[k] = 1'b0; armed[k] = 1'b0; dly[k] = 0; late_ack[k] = 1'b0; ack_cnt[k] = 0;
      alog_n[k] = 0; dlog_n[k] = 0; accept_cyc[k] = 0; last_ack_cyc[k] = 0; fill_cyc[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_mem_addr", 32'(mem_addr[k]), 32'h0);
      chk(k, "rst_data", 32'(dfs[k]), 32'h0);
      chk(k, "rst_fill", 32'(sdram_fill[k]), 32'h0);
      chk(k, "rst_mem_req", 32'(mem_req[k]), 32'h0);
      chk(k, "rst_busy", 32'(busy[k]), 32'h0);
      chk(k, "rst_perr", 32'(perr[k]), 32'h0);
    end

    // Fixed-address fills with backend mem[h]=h and single-cycle acks.
    ident = 1'b1; maxdly = 0;
    for (int k = 0; k < 2; k++) begin
      alog_n[k] = 0; dlog_n[k] = 0;
      do_read(k, 32'h0000123C, 3);
      chk(k, "fixed_ack_count", 32'(alog_n[k]), 32'd8);
      chk(k, "fixed_burst_len", 32'(dlog_n[k]), 32'd8);
      for (int i = 0; i < 8; i++) begin
        chk(k, "fixed_addr_seq", 32'(alog[k][i]), (k == 0) ? 32'(exp_cf[i]) : 32'h918 + 32'(i));
        chk(k, "fixed_burst_data", 32'(dlog[k][i]), (k == 0) ? 32'(exp_cf[i]) : 32'h918 + 32'(i));
      end
      // Request cycle to strobe is 10 cycles counting the request cycle itself.
      chk(k, "req_to_fill", 32'(fill_cyc[k] - accept_cyc[k]), 32'd9);
      chk(k, "ack_to_fill", 32'(fill_cyc[k] - last_ack_cyc[k]), 32'd1);
    end

    // Random addresses, data and backend waits; gap 0 exercises back-to-back.
    ident = 1'b0; maxdly = 5;
    for (int n = 0; n < 12; n++) do_read(n % 2, $urandom, $urandom_range(0, 3));
    for (int n = 0; n < 3; n++) do_read(0, $urandom, 0);
    for (int n = 0; n < 3; n++) do_read(1, $urandom, 0);

    // Write requests are flagged and the next read still completes.
    do_write(0);
    do_write(1);
    do_read(0, $urandom, 2);
    do_read(1, $urandom, 2);
    chk(0, "perr_sticky", 32'(perr[0]), 32'h1);

    // Reset after three acks, then a stray ack while idle.
    maxdly = 0;
    t = ack_cnt[0];
    @(posedge clk); #1;
    sdram_req[0] = 1'b1; sdram_rw[0] = 1'b1; sdram_addr[0] = $urandom;
    for (int w = 0; w < 50 && ack_cnt[0] < t + 3; w++) begin
      @(posedge clk); #1;
    end
    chk(0, "acks_before_reset", 32'(ack_cnt[0] - t), 32'd3);
    reset = 1'b1; sdram_req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; late_ack[0] = 1'b1;
    chk(0, "post_reset_mem_req", 32'(mem_req[0]), 32'h0);
    chk(0, "post_reset_busy", 32'(busy[0]), 32'h0);
    chk(0, "post_reset_perr", 32'(perr[0]), 32'h0);
    @(posedge clk); #1;
    late_ack[0] = 1'b0;
    chk(0, "late_ack_ignored", 32'(busy[0]), 32'h0);
    alog_n[0] = 0;
    maxdly = 5;
    do_read(0, $urandom, 2);
    chk(0, "refetch_count", 32'(alog_n[0]), 32'd8);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
